// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder
// ----------------------------------------------------------------------------
// Target side of the CPU data-memory request interface (DM_CS/DM_R/DM_W).
// Accepts one 32-bit word read or write per request, waits WAIT_CYCLES
// clocks, then answers with a one-cycle dm_ready pulse. Requests are backed
// by an internal word-addressed storage array of DEPTH words.
//
// Timing: a request accepted on edge N produces dm_ready high for the single
// cycle following edge N+1+WAIT_CYCLES. The next request can be accepted on
// the edge that ends that dm_ready cycle.
//
// Optional build macro:
//   DMEM_ALIGN_CHECK_EN - when defined, a request whose addr[1:0] is non-zero
//                         is answered with dm_err=1 and has no side effect.
//                         When undefined, addr[1:0] is ignored.
//
// Ports:
//   clk_in    in   1   system clock, rising edge
//   reset     in   1   asynchronous active-low reset
//   dm_cs     in   1   request chip select
//   dm_r      in   1   read qualifier
//   dm_w      in   1   write qualifier
//   addr      in  32   byte address (addr[ADDR_W+1:2] selects the word)
//   wdata     in  32   write data
//   rdata     out 32   read data, registered, holds last read value
//   dm_ready  out  1   one-cycle response pulse
//   dm_err    out  1   error flag, meaningful only while dm_ready=1
// ============================================================================
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        dm_cs,
    input  logic        dm_r,
    input  logic        dm_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        dm_ready,
    output logic        dm_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LD = WAIT_CYCLES[7:0];

    // Storage array: deliberately not reset, contents survive reset.
    logic [31:0]       mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              opw_q, opw_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              derr_q, derr_d;
    logic              mem_we_s;
    logic              req_s;
    logic              req_err_s;

    // Bits of addr that never select a word are collected here on purpose.
    logic              unused_addr_s;
    assign unused_addr_s = ^{addr[31:ADDR_W+2], addr[1:0]};

    // Request detection and error classification at acceptance time.
    assign req_s = dm_cs & (dm_r | dm_w);
`ifdef DMEM_ALIGN_CHECK_EN
    assign req_err_s = (dm_r & dm_w) | (addr[1:0] != 2'b00);
`else
    assign req_err_s = dm_r & dm_w;
`endif

    // Next-state, capture and response logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        opw_d    = opw_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        derr_d   = 1'b0;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    idx_d   = addr[ADDR_W+1:2];
                    wdata_d = wdata;
                    opw_d   = dm_w;
                    err_d   = req_err_s;
                    cnt_d   = WAIT_LD;
                    if (WAIT_LD == 8'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Leave on the last wait cycle; <= also guards a corrupted count.
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                // The edge leaving RESP raises dm_ready and performs the access.
                ready_d = 1'b1;
                derr_d  = err_q;
                state_d = ST_IDLE;
                if (err_q) begin
                    mem_we_s = 1'b0;
                end else if (opw_q) begin
                    mem_we_s = 1'b1;
                end else begin
                    rdata_d = mem_q[idx_q];
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Control, capture and output registers with asynchronous reset.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            opw_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            opw_q   <= opw_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            derr_q  <= derr_d;
        end
    end

    // Storage write port; gated by RESP state so an aborted request never commits.
    always_ff @(posedge clk_in) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign rdata    = rdata_q;
    assign dm_ready = ready_q;
    assign dm_err   = derr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder
// Directed plus randomized stimulus for dmem_responder (DEPTH=1024,
// WAIT_CYCLES=2). Expected values come from a word-array reference model that
// applies the request rules directly: error requests have no effect, writes
// update the word at (addr/4) mod DEPTH, reads return that word.
// ============================================================================
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 1024;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        dm_cs, dm_r, dm_w;
    logic [31:0] addr, wdata, rdata;
    logic        dm_ready, dm_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_mem [DEPTH];
    bit          known   [DEPTH];
    int          known_q [$];
    logic [31:0] exp_rdata;

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(10), .WAIT_CYCLES(W)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .dm_cs    (dm_cs),
        .dm_r     (dm_r),
        .dm_w     (dm_w),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .dm_ready (dm_ready),
        .dm_err   (dm_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        dm_cs = 1'b0;
        dm_r  = 1'b0;
        dm_w  = 1'b0;
        addr  = $urandom;
        wdata = $urandom;
    endtask

    task automatic rand_inputs();
        dm_cs = 1'($urandom);
        dm_r  = 1'($urandom);
        dm_w  = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in); #1;
            check(tag, {31'd0, dm_ready}, 32'd0);
        end
    endtask

    // One full request: drive, accept, scramble inputs while waiting, verify
    // the exact dm_ready cycle, then the error flag and read data.
    task automatic do_req(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int idx;
        bit err;
        idx = int'(a[11:2]);
        err = r & w;
`ifdef DMEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) err = 1'b1;
`endif
        dm_cs = 1'b1; dm_r = r; dm_w = w; addr = a; wdata = d;
        @(posedge clk_in); #1;
        rand_inputs();
        if (!err) begin
            if (w) begin
                exp_mem[idx] = d;
                if (!known[idx]) known_q.push_back(idx);
                known[idx] = 1'b1;
            end else begin
                exp_rdata = exp_mem[idx];
            end
        end
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clk_in); #1;
            check({tag, "_ready"}, {31'd0, dm_ready}, (k == W + 1) ? 32'd1 : 32'd0);
            if (k < W + 1) rand_inputs();
        end
        check({tag, "_err"}, {31'd0, dm_err}, {31'd0, err});
        check({tag, "_rdata"}, rdata, exp_rdata);
        idle_inputs();
    endtask

    initial begin
        exp_rdata = 32'd0;
        // Reset held with random inputs.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            @(posedge clk_in); #1;
            check("rst_ready", {31'd0, dm_ready}, 32'd0);
            check("rst_err", {31'd0, dm_err}, 32'd0);
            check("rst_rdata", rdata, 32'd0);
        end
        idle_inputs();
        reset = 1'b1;
        idle_cycles(5, "idle_ready");

        // Basic write/read.
        do_req(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr10");
        idle_cycles(1, "post_wr_ready");
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, "rd10");

        // Error request: no write, rdata held.
        do_req(1'b1, 1'b1, 32'h0000_0010, 32'h5555_5555, "err10");
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, "rd10_after_err");

        // Aliasing modulo DEPTH*4 and newest-value read.
        do_req(1'b0, 1'b1, 32'h0000_1004, 32'h1234_5678, "wr1004");
        do_req(1'b1, 1'b0, 32'h0000_0004, 32'h0, "rd4_alias");
        do_req(1'b0, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, "wr4");
        do_req(1'b0, 1'b1, 32'hFFFF_F004, 32'h0BAD_CAFE, "wr4_again");
        do_req(1'b1, 1'b0, 32'h0000_1004, 32'h0, "rd1004_newest");

        // Misaligned write: behaviour depends on the alignment check build.
        do_req(1'b0, 1'b1, 32'h0000_0012, 32'h0BAD_F00D, "wr12_misal");
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, "rd10_after_misal");

        // Reset during WAIT aborts the write.
        do_req(1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, "wr20");
        dm_cs = 1'b1; dm_r = 1'b0; dm_w = 1'b1; addr = 32'h20; wdata = 32'hA5A5_A5A5;
        @(posedge clk_in); #1;
        idle_inputs();
        @(posedge clk_in); #1;
        reset = 1'b0;
        #1;
        check("midrst_ready", {31'd0, dm_ready}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        exp_rdata = 32'd0;
        @(posedge clk_in);
        @(posedge clk_in); #1;
        reset = 1'b1;
        idle_cycles(3, "midrst_idle_ready");
        do_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, "rd20_after_abort");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                do_req(1'b0, 1'b1, $urandom, $urandom, "rnd_wr");
            end else if (kind == 2) begin
                a = $urandom;
                a[11:2] = 10'(known_q[$urandom_range(0, known_q.size() - 1)]);
                do_req(1'b1, 1'b0, a, $urandom, "rnd_rd");
            end else begin
                do_req(1'b1, 1'b1, $urandom, $urandom, "rnd_err");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
